// File: rtl/sprite_blitter_if.sv
// Draw-queue, sprite-memory and framebuffer signals of the sprite blitter.
// master = blitter side, slave = command driver / memories side.
interface sprite_blitter_if #(
  parameter int ID_BITS     = 3,
  parameter int SPRITE_LOG2 = 5,
  parameter int FB_ADDR_W   = 17
);
  logic                               is_empty;
  logic                               dequeue;
  logic [7:0]                         sprite_id;
  logic [15:0]                        sprite_x;
  logic [15:0]                        sprite_y;
  logic [7:0]                         sprite_scale;
  logic                               sprite_r_en;
  logic [ID_BITS+2*SPRITE_LOG2-1:0]   sprite_r_addr;
  logic [3:0]                         sprite_r_data;
  logic                               fb_we;
  logic [FB_ADDR_W-1:0]               fb_addr;
  logic [3:0]                         fb_data;
  logic                               fb_ready;
  logic                               busy;
  logic                               blit_done;

  modport master (
    input  is_empty, sprite_id, sprite_x, sprite_y, sprite_scale,
    input  sprite_r_data, fb_ready,
    output dequeue, sprite_r_en, sprite_r_addr,
    output fb_we, fb_addr, fb_data, busy, blit_done
  );

  modport slave (
    output is_empty, sprite_id, sprite_x, sprite_y, sprite_scale,
    output sprite_r_data, fb_ready,
    input  dequeue, sprite_r_en, sprite_r_addr,
    input  fb_we, fb_addr, fb_data, busy, blit_done
  );
endinterface

// File: rtl/sprite_blitter.sv
// Pops draw commands and writes scaled, clipped, colour-keyed sprite pixels to the framebuffer.
// Three cycles per destination pixel; a writable pixel holds fb_we/fb_addr/fb_data until fb_ready.
module sprite_blitter #(
  parameter int ID_BITS     = 3,
  parameter int SPRITE_LOG2 = 5,
  parameter int MAX_SCALE   = 4,
  parameter int FB_W        = 320,
  parameter int FB_H        = 240,
  parameter int FB_ADDR_W   = 17
) (
  input  logic          sys_clock,
  input  logic          reset_n,
  sprite_blitter_if.master bus
);

  localparam int SW = $clog2(MAX_SCALE + 1);
  localparam int DW = SPRITE_LOG2 + SW;
  localparam int AW = ID_BITS + 2 * SPRITE_LOG2;
  localparam logic [16:0] FB_W17 = 17'(FB_W);
  localparam logic [16:0] FB_H17 = 17'(FB_H);

  typedef enum logic [2:0] {IDLE, POP, ISSUE, CAPTURE, WRITE, DONE} state_t;

  state_t                  state;
  logic [ID_BITS-1:0]      id;
  logic [15:0]             x0;
  logic [15:0]             y0;
  logic [SW-1:0]           s;
  logic [DW-1:0]           dx, dy;
  logic [SW-1:0]           subx, suby;
  logic [SPRITE_LOG2-1:0]  col, row;

  logic                    deq;
  logic                    rd_en;
  logic [AW-1:0]           rd_addr;
  logic                    we;
  logic [FB_ADDR_W-1:0]    addr;
  logic [3:0]              data;
  logic                    busy_q;
  logic                    done_p;

  logic [SW-1:0]           s_in;
  logic [DW-1:0]           last;
  logic [16:0]             cur_x, cur_y, y_next;
  logic                    writable;
  logic [FB_ADDR_W-1:0]    lin_addr;
  logic [DW-1:0]           dx_n, dy_n;
  logic [SW-1:0]           subx_n, suby_n;
  logic [SPRITE_LOG2-1:0]  col_n, row_n;
  logic                    row_end, last_pix, early;
  logic                    unused_id_bits;

  assign unused_id_bits = ^bus.sprite_id[7:ID_BITS];

  always_comb begin
    s_in = bus.sprite_scale[SW-1:0];
    if (bus.sprite_scale == 8'd0)
      s_in = SW'(1);
    else if (bus.sprite_scale > 8'(MAX_SCALE))
      s_in = SW'(MAX_SCALE);
  end

  assign last     = (DW'(s) << SPRITE_LOG2) - DW'(1);
  assign cur_x    = {1'b0, x0} + 17'(dx);
  assign cur_y    = {1'b0, y0} + 17'(dy);
  assign writable = (bus.sprite_r_data != 4'd0) && (cur_x < FB_W17) && (cur_y < FB_H17);
  assign lin_addr = FB_ADDR_W'(cur_y * FB_W17 + cur_x);

  // Sub-counters divide the destination offsets by the scale without a divider.
  always_comb begin
    dx_n   = dx + DW'(1);
    subx_n = subx + SW'(1);
    col_n  = col;
    dy_n   = dy;
    suby_n = suby;
    row_n  = row;
    if (subx == s - SW'(1)) begin
      subx_n = '0;
      col_n  = col + SPRITE_LOG2'(1);
    end
    if (row_end) begin
      dx_n   = '0;
      subx_n = '0;
      col_n  = '0;
      dy_n   = dy + DW'(1);
      suby_n = suby + SW'(1);
      if (suby == s - SW'(1)) begin
        suby_n = '0;
        row_n  = row + SPRITE_LOG2'(1);
      end
    end
  end

  assign row_end  = (dx == last);
  assign last_pix = row_end && (dy == last);
  assign y_next   = {1'b0, y0} + 17'(dy_n);
  assign early    = row_end && (y_next >= FB_H17);

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      id      <= '0;
      x0      <= '0;
      y0      <= '0;
      s       <= '0;
      dx      <= '0;
      dy      <= '0;
      subx    <= '0;
      suby    <= '0;
      col     <= '0;
      row     <= '0;
      deq     <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      we      <= 1'b0;
      addr    <= '0;
      data    <= '0;
      busy_q  <= 1'b0;
      done_p  <= 1'b0;
    end else begin
      deq    <= 1'b0;
      rd_en  <= 1'b0;
      done_p <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.is_empty) begin
            deq   <= 1'b1;
            id    <= bus.sprite_id[ID_BITS-1:0];
            x0    <= bus.sprite_x;
            y0    <= bus.sprite_y;
            s     <= s_in;
            state <= POP;
          end
        end
        POP: begin
          busy_q  <= 1'b1;
          dx      <= '0;
          dy      <= '0;
          subx    <= '0;
          suby    <= '0;
          col     <= '0;
          row     <= '0;
          rd_en   <= 1'b1;
          rd_addr <= {id, {(2*SPRITE_LOG2){1'b0}}};
          state   <= ISSUE;
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          we <= writable;
          // Address/data only move for real writes so the bus never shows off-screen addresses.
          if (writable) begin
            addr <= lin_addr;
            data <= bus.sprite_r_data;
          end
          state <= WRITE;
        end
        WRITE: begin
          if (!we || bus.fb_ready) begin
            we <= 1'b0;
            if (last_pix || early) begin
              state <= DONE;
            end else begin
              dx      <= dx_n;
              dy      <= dy_n;
              subx    <= subx_n;
              suby    <= suby_n;
              col     <= col_n;
              row     <= row_n;
              rd_en   <= 1'b1;
              rd_addr <= {id, row_n, col_n};
              state   <= ISSUE;
            end
          end
        end
        DONE: begin
          done_p <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dequeue       = deq;
  assign bus.sprite_r_en   = rd_en;
  assign bus.sprite_r_addr = rd_addr;
  assign bus.fb_we         = we;
  assign bus.fb_addr       = addr;
  assign bus.fb_data       = data;
  assign bus.busy          = busy_q;
  assign bus.blit_done     = done_p;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: queue/memory models, reference scoreboard of framebuffer writes.
module tb_sprite_blitter;

  typedef struct {
    int id;
    int x;
    int y;
    int scale;
  } cmd_t;

  logic sys_clock = 1'b0;
  logic reset_n   = 1'b0;

  sprite_blitter_if #(.ID_BITS(3), .SPRITE_LOG2(5), .FB_ADDR_W(17)) bus ();

  sprite_blitter #(
    .ID_BITS(3), .SPRITE_LOG2(5), .MAX_SCALE(4),
    .FB_W(320), .FB_H(240), .FB_ADDR_W(17)
  ) dut (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  initial forever #5 sys_clock = ~sys_clock;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   done_seen = 0;
  int   t_pop = 0;
  int   cmd_writes = 0;
  bit   stall_mode = 0;
  cmd_t cmd_q[$];
  int   exp_addr[$];
  int   exp_data[$];
  int   exp_n_q[$];
  int   exp_cyc_q[$];
  int   w_addr[4];
  int   w_data[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Test pattern stored in sprite memory; id=2 reduces to (col+row)&0xF.
  function automatic logic [3:0] pix(input int sid, input int row, input int col);
    return 4'((col + row + 3 * sid + 10) & 15);
  endfunction

  // Reference: every destination pixel in raster order, kept if on-screen and opaque.
  task automatic push_expect(input cmd_t c);
    int s, e, n, rows, px, py;
    logic [3:0] p;
    s = (c.scale == 0) ? 1 : ((c.scale > 4) ? 4 : c.scale);
    e = 32 * s;
    n = 0;
    for (int dy = 0; dy < e; dy++) begin
      for (int dx = 0; dx < e; dx++) begin
        px = c.x + dx;
        py = c.y + dy;
        if (px < 320 && py < 240) begin
          p = pix(c.id % 8, dy / s, dx / s);
          if (p != 4'd0) begin
            exp_addr.push_back(py * 320 + px);
            exp_data.push_back(int'(p));
            n++;
          end
        end
      end
    end
    rows = (c.y >= 240) ? 1 : (((240 - c.y) < e) ? (240 - c.y) : e);
    exp_n_q.push_back(n);
    exp_cyc_q.push_back(stall_mode ? -1 : 3 * rows * e + 2);
  endtask

  initial forever begin
    @(posedge sys_clock);
    cyc++;
  end

  // Sprite memory: synchronous read, garbage on cycles without a read.
  initial begin
    logic       rd;
    logic [3:0] v;
    bus.sprite_r_data = 4'd0;
    forever begin
      @(negedge sys_clock);
      rd = bus.sprite_r_en;
      v  = pix(int'(bus.sprite_r_addr[12:10]), int'(bus.sprite_r_addr[9:5]), int'(bus.sprite_r_addr[4:0]));
      @(posedge sys_clock);
      #1;
      bus.sprite_r_data = rd ? v : 4'($urandom);
    end
  end

  // Draw queue and framebuffer ready driver.
  initial begin
    cmd_t c;
    bus.is_empty     = 1'b1;
    bus.sprite_id    = 8'd0;
    bus.sprite_x     = 16'd0;
    bus.sprite_y     = 16'd0;
    bus.sprite_scale = 8'd0;
    bus.fb_ready     = 1'b1;
    forever begin
      @(posedge sys_clock);
      #2;
      if (reset_n && bus.dequeue && cmd_q.size() > 0) begin
        c = cmd_q.pop_front();
        push_expect(c);
      end
      bus.is_empty = (cmd_q.size() == 0);
      if (cmd_q.size() > 0) begin
        bus.sprite_id    = 8'(cmd_q[0].id);
        bus.sprite_x     = 16'(cmd_q[0].x);
        bus.sprite_y     = 16'(cmd_q[0].y);
        bus.sprite_scale = 8'(cmd_q[0].scale);
      end else begin
        bus.sprite_id    = 8'($urandom);
        bus.sprite_x     = 16'($urandom);
        bus.sprite_y     = 16'($urandom);
        bus.sprite_scale = 8'($urandom);
      end
      bus.fb_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit         prev_stall;
    logic [16:0] prev_addr;
    logic [3:0]  prev_data;
    int ea, ed, en, ec;
    prev_stall = 0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge sys_clock);
      if (!reset_n) begin
        prev_stall = 0;
      end else begin
        if (bus.dequeue) begin
          chk("dequeue_while_busy", 32'(bus.busy), 0);
          t_pop      = cyc;
          cmd_writes = 0;
        end
        if (prev_stall) begin
          chk("stall_hold_we", 32'(bus.fb_we), 1);
          chk("stall_hold_addr", 32'(bus.fb_addr), 32'(prev_addr));
          chk("stall_hold_data", 32'(bus.fb_data), 32'(prev_data));
        end
        prev_stall = bus.fb_we && !bus.fb_ready;
        prev_addr  = bus.fb_addr;
        prev_data  = bus.fb_data;
        if (bus.fb_we) begin
          chk("addr_in_range", 32'(bus.fb_addr < 17'd76800), 1);
          if (bus.fb_ready) begin
            if (exp_addr.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_write: got addr %0d expected no write", bus.fb_addr);
            end else begin
              ea = exp_addr.pop_front();
              ed = exp_data.pop_front();
              chk("write_addr", 32'(bus.fb_addr), ea);
              chk("write_data", 32'(bus.fb_data), ed);
            end
            if (cmd_writes < 4) begin
              w_addr[cmd_writes] = int'(bus.fb_addr);
              w_data[cmd_writes] = int'(bus.fb_data);
            end
            cmd_writes++;
          end
        end
        if (bus.blit_done) begin
          if (exp_n_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got blit_done expected none");
          end else begin
            en = exp_n_q.pop_front();
            ec = exp_cyc_q.pop_front();
            chk("cmd_write_count", cmd_writes, en);
            if (ec >= 0) chk("pop_to_done_cycles", cyc - t_pop, ec);
          end
          done_seen++;
        end
      end
    end
  end

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_seen < target && n < budget) begin
      @(posedge sys_clock);
      n++;
    end
    if (done_seen < target) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d completions expected %0d", done_seen, target);
    end
  endtask

  task automatic run_cmd(input int id, input int x, input int y, input int scale, input int budget);
    cmd_t c;
    int tgt;
    c.id = id; c.x = x; c.y = y; c.scale = scale;
    tgt = done_seen + 1;
    cmd_q.push_back(c);
    wait_done(tgt, budget);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_dequeue"},   32'(bus.dequeue), 0);
    chk({tag, "_r_en"},      32'(bus.sprite_r_en), 0);
    chk({tag, "_r_addr"},    32'(bus.sprite_r_addr), 0);
    chk({tag, "_fb_we"},     32'(bus.fb_we), 0);
    chk({tag, "_fb_addr"},   32'(bus.fb_addr), 0);
    chk({tag, "_fb_data"},   32'(bus.fb_data), 0);
    chk({tag, "_busy"},      32'(bus.busy), 0);
    chk({tag, "_blit_done"}, 32'(bus.blit_done), 0);
  endtask

  initial begin
    cmd_t c;
    int   tgt, n;
    repeat (3) @(posedge sys_clock);
    #1;
    chk_outputs_zero("reset");
    @(posedge sys_clock);
    #3;
    reset_n = 1'b1;

    // Directed, fb_ready held high so completion timing is checked too.
    run_cmd(2, 8, 10, 1, 5000);
    chk("s1_first_write_addr", 32'(w_addr[0]), 10 * 320 + 9);
    chk("s1_first_write_data", 32'(w_data[0]), 1);
    run_cmd(2, 8, 10, 2, 15000);
    chk("s2_dx3_addr", 32'(w_addr[1]), 10 * 320 + 11);
    chk("s2_dx3_data", 32'(w_data[1]), 1);
    run_cmd(2, 8, 16'h121A, 2, 1000);
    run_cmd(2, 300, 230, 1, 2000);
    run_cmd(13, 5, 3, 0, 5000);

    // Reset in the middle of the first of two queued commands.
    c.id = 2; c.x = 8; c.y = 10; c.scale = 1;
    cmd_q.push_back(c);
    c.id = 5; c.x = 100; c.y = 50; c.scale = 1;
    cmd_q.push_back(c);
    n = 0;
    while (!bus.busy && n < 100) begin
      @(posedge sys_clock);
      n++;
    end
    repeat (300) @(posedge sys_clock);
    #1;
    chk("busy_before_reset", 32'(bus.busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    exp_addr.delete();
    exp_data.delete();
    exp_n_q.delete();
    exp_cyc_q.delete();
    repeat (3) @(posedge sys_clock);
    #3;
    reset_n = 1'b1;
    tgt = done_seen + 1;
    wait_done(tgt, 5000);
    chk("queue_drained_after_reset", 32'(cmd_q.size()), 0);

    // Random framebuffer stalls, commands queued back to back.
    stall_mode = 1;
    tgt = done_seen + 4;
    c.id = 2; c.x = 8; c.y = 10; c.scale = 1;
    cmd_q.push_back(c);
    for (int i = 0; i < 2; i++) begin
      c.id    = $urandom_range(0, 255);
      c.x     = $urandom_range(0, 340);
      c.y     = $urandom_range(200, 260);
      c.scale = $urandom_range(0, 2);
      cmd_q.push_back(c);
    end
    c.id = $urandom_range(0, 255); c.x = $urandom_range(0, 300); c.y = 230; c.scale = 9;
    cmd_q.push_back(c);
    wait_done(tgt, 60000);
    stall_mode = 0;
    repeat (5) @(posedge sys_clock);
    chk("scoreboard_empty", 32'(exp_addr.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
